// File: rtl/paddle_input.sv
// paddle_input: raw push-buttons to paddle Y positions and command pulses.
// Six buttons are synchronised and debounced. Up/down presses move two
// 11-bit paddle centres once per movement tick, bounded by the playfield
// walls for the current bat size. Serve/start presses become single-cycle
// pulses. Both paddles are held at the centre while the game is in START.
module paddle_input #(
  parameter int DEB_CYCLES = 250000,
  parameter int TICK_DIV   = 100000,
  parameter int STEP       = 2,
  parameter int Y_INIT     = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  input  logic        serve_btn,
  input  logic        start_btn,
  input  logic        bat_size,
  input  logic        start_state,
  output logic [10:0] p1_y,
  output logic [10:0] p2_y,
  output logic        serve_p,
  output logic        start_p
);

  localparam int NBTN = 6;
  localparam int DW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  // Button bit positions inside the packed vectors below.
  localparam int B_P1_UP = 0;
  localparam int B_P1_DN = 1;
  localparam int B_P2_UP = 2;
  localparam int B_P2_DN = 3;
  localparam int B_SERVE = 4;
  localparam int B_START = 5;

  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] s1;
  logic [NBTN-1:0] s2;
  logic [NBTN-1:0] stable;
  logic [DW-1:0]   deb_cnt [NBTN];
  logic [1:0]      stable_d;   // previous serve/start stable levels
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [11:0]     half;
  logic [11:0]     y_min;
  logic [11:0]     y_max;
  logic [10:0]     p1_y_next;
  logic [10:0]     p2_y_next;

  assign raw = {start_btn, serve_btn, p2_dn, p2_up, p1_dn, p1_up};

  // Two-flop synchroniser for every raw button.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, giving a true s1 -> s2 shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debouncer: stable follows s2 only after DEB_CYCLES disagreeing samples.
  // NOTE: the counter array is small and must start from zero after reset,
  // so every element is cleared in the reset branch rather than left as a
  // reset-less memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (s2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          stable[i]  <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Free-running movement tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Playfield limits for the current bat size.
  // NOTE: every always_comb output gets a default first so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    half  = 12'd29;
    if (bat_size) half = 12'd19;
    y_min = 12'd30 + half;
    y_max = 12'd450 - half;
  end

  // One paddle step in 12-bit arithmetic: recentre, move, or re-clamp.
  function automatic logic [10:0] paddle_next(
    input logic [10:0] y,
    input logic        up,
    input logic        dn,
    input logic        tk,
    input logic        recentre,
    input logic [11:0] lo,
    input logic [11:0] hi
  );
    logic [11:0] y12;
    logic [11:0] t;
    y12 = {1'b0, y};
    t   = y12;
    if (recentre) begin
      t = 12'(Y_INIT);
    end else if (tk && up && !dn) begin
      t = y12 - 12'(STEP);
      if (t < lo) t = lo;
    end else if (tk && dn && !up) begin
      t = y12 + 12'(STEP);
      if (t > hi) t = hi;
    end else begin
      if (t < lo)      t = lo;
      else if (t > hi) t = hi;
    end
    return t[10:0];
  endfunction

  // Next paddle positions for both players.
  always_comb begin
    p1_y_next = paddle_next(p1_y, stable[B_P1_UP], stable[B_P1_DN], tick,
                            start_state, y_min, y_max);
    p2_y_next = paddle_next(p2_y, stable[B_P2_UP], stable[B_P2_DN], tick,
                            start_state, y_min, y_max);
  end

  // Paddle position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_y <= 11'(Y_INIT);
      p2_y <= 11'(Y_INIT);
    end else begin
      p1_y <= p1_y_next;
      p2_y <= p2_y_next;
    end
  end

  // Registered rising-edge pulses for serve and start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
      serve_p  <= 1'b0;
      start_p  <= 1'b0;
    end else begin
      stable_d <= {stable[B_START], stable[B_SERVE]};
      serve_p  <= stable[B_SERVE] & ~stable_d[0];
      start_p  <= stable[B_START] & ~stable_d[1];
    end
  end

endmodule

// File: tb/tb_paddle_input.sv
// Self-checking bench for paddle_input with small timing parameters.
module tb_paddle_input;

  localparam int DEB  = 4;
  localparam int TDIV = 8;
  localparam int STP  = 2;
  localparam int YI   = 240;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic        serve_btn = 1'b0, start_btn = 1'b0;
  logic        bat_size = 1'b0, start_state = 1'b0;
  logic [10:0] p1_y, p2_y;
  logic        serve_p, start_p;

  int errors = 0;
  int checks = 0;

  paddle_input #(
    .DEB_CYCLES(DEB), .TICK_DIV(TDIV), .STEP(STP), .Y_INIT(YI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .serve_btn(serve_btn), .start_btn(start_btn),
    .bat_size(bat_size), .start_state(start_state),
    .p1_y(p1_y), .p2_y(p2_y), .serve_p(serve_p), .start_p(start_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] btn;     // {p2_dn, p2_up, p1_dn, p1_up}
    logic       bat;
    logic       st;
    int         cycles;
    int         exp1;
    int         exp2;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_s, n_t, at_s, at_t;

    vecs[0]  = '{"up_sat_59",      4'b0001, 1'b0, 1'b0,  800,  59, 240};
    vecs[1]  = '{"p2_conflict",    4'b1100, 1'b0, 1'b0,  100,  59, 240};
    vecs[2]  = '{"dn_sat_421",     4'b0010, 1'b0, 1'b0, 1600, 421, 240};
    vecs[3]  = '{"idle_421",       4'b0000, 1'b0, 1'b0,   20, 421, 240};
    vecs[4]  = '{"bat1_keep_421",  4'b0000, 1'b1, 1'b0,    1, 421, 240};
    vecs[5]  = '{"bat1_up_49",     4'b0001, 1'b1, 1'b0, 2000,  49, 240};
    vecs[6]  = '{"bat0_reclamp",   4'b0001, 1'b0, 1'b0,    1,  59, 240};
    vecs[7]  = '{"p2_dn_sat_421",  4'b1000, 1'b0, 1'b0, 1600,  59, 421};
    vecs[8]  = '{"recentre_1cyc",  4'b0110, 1'b0, 1'b1,    1, 240, 240};
    vecs[9]  = '{"recentre_hold",  4'b0110, 1'b0, 1'b1,   50, 240, 240};
    vecs[10] = '{"recentre_idle",  4'b0000, 1'b0, 1'b1,   20, 240, 240};

    // Reset values while rst_n is low.
    cyc(3);
    check("rst_p1_y", 32'(p1_y), 32'(YI));
    check("rst_p2_y", 32'(p2_y), 32'(YI));
    check("rst_serve_p", 32'(serve_p), 0);
    check("rst_start_p", 32'(start_p), 0);

    // Exact step timing from release: stable up at edge 6, ticks at 8, 16.
    @(negedge clk);
    rst_n = 1'b1;
    p1_up = 1'b1;
    cyc(7);
    check("step_before_tick", 32'(p1_y), 240);
    cyc(1);
    check("step_tick1", 32'(p1_y), 238);
    cyc(7);
    check("step_hold", 32'(p1_y), 238);
    cyc(1);
    check("step_tick2", 32'(p1_y), 236);

    // Asynchronous reset mid-cycle, observed before any clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    p1_up = 1'b0;
    #1;
    check("async_rst_p1_y", 32'(p1_y), 32'(YI));
    check("async_rst_p2_y", 32'(p2_y), 32'(YI));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Movement, clamp, reclamp and recentre table.
    for (int i = 0; i < 11; i++) begin
      {p2_dn, p2_up, p1_dn, p1_up} = vecs[i].btn;
      bat_size    = vecs[i].bat;
      start_state = vecs[i].st;
      cyc(vecs[i].cycles);
      check({vecs[i].name, "_p1"}, 32'(p1_y), 32'(vecs[i].exp1));
      check({vecs[i].name, "_p2"}, 32'(p2_y), 32'(vecs[i].exp2));
    end
    {p2_dn, p2_up, p1_dn, p1_up} = 4'b0000;
    start_state = 1'b0;
    cyc(10);

    // Glitch of 3 cycles never produces a serve pulse.
    n_s = 0;
    for (int i = 0; i < 23; i++) begin
      serve_btn = (i < 3);
      cyc(1);
      if (serve_p) n_s++;
    end
    check("glitch_serve_count", 32'(n_s), 0);

    // Held serve: one pulse, DEB+3 cycles after the raw edge.
    n_s = 0;
    at_s = -1;
    serve_btn = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      cyc(1);
      if (serve_p) begin
        n_s++;
        at_s = i;
      end
    end
    check("held_serve_count", 32'(n_s), 1);
    check("held_serve_latency", 32'(at_s), 32'(DEB + 3));

    // Serve release plus bouncing start: one start pulse, no serve pulse.
    serve_btn = 1'b0;
    n_s = 0;
    n_t = 0;
    for (int i = 0; i < 60; i++) begin
      start_btn = (i < 6) ? ((i % 2) == 0) : 1'b1;
      cyc(1);
      if (serve_p) n_s++;
      if (start_p) n_t++;
    end
    check("release_serve_count", 32'(n_s), 0);
    check("bounce_start_count", 32'(n_t), 1);

    // Reset mid-debounce with buttons held: both re-debounce as new presses.
    serve_btn = 1'b1;
    cyc(4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_serve_p", 32'(serve_p), 0);
    check("midrst_start_p", 32'(start_p), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_s = 0;
    n_t = 0;
    at_s = -1;
    at_t = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (serve_p) begin
        n_s++;
        at_s = i;
      end
      if (start_p) begin
        n_t++;
        at_t = i;
      end
    end
    check("repress_serve_count", 32'(n_s), 1);
    check("repress_serve_at", 32'(at_s), 32'(DEB + 3));
    check("repress_start_count", 32'(n_t), 1);
    check("repress_start_at", 32'(at_t), 32'(DEB + 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
